// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back path.
// Contents: data/address widths, controller state enum, write-back source IDs,
// and the read-port bypass helper used by regfile_ctrl.
package regfile_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned NREG   = 32;
   localparam int unsigned REG_AW = 5;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]   xdata_t;

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   // Index into the two-bit request/grant vectors.
   localparam logic SRC_EX = 1'b0;
   localparam logic SRC_LD = 1'b1;

   // x0 reads as zero; a write presented this cycle wins over the stale SRAM word.
   function automatic xdata_t bypass(input reg_addr_t addr, input logic we,
                                     input reg_addr_t wa, input xdata_t wd,
                                     input xdata_t q);
      if (addr == '0) begin
         return '0;
      end else if (we && (wa == addr)) begin
         return wd;
      end else begin
         return q;
      end
   endfunction

endpackage

// File: rtl/regfile_ctrl_if.sv
// Bus bundle between the write-back sources, the register-file SRAM and regfile_ctrl.
// Groups: ex/ld valid-ready write-back requests, registered SRAM write port,
// two read ports (address out, raw data in, bypassed data back) and init_done.
// slave = controller side, master = environment side.
interface regfile_ctrl_if;

   logic                      ex_valid;
   regfile_pkg::reg_addr_t    ex_rd;
   regfile_pkg::xdata_t       ex_data;
   logic                      ex_ready;

   logic                      ld_valid;
   regfile_pkg::reg_addr_t    ld_rd;
   regfile_pkg::xdata_t       ld_data;
   logic                      ld_ready;

   logic                      rf_we;
   regfile_pkg::reg_addr_t    rf_rd;
   regfile_pkg::xdata_t       rf_di;

   regfile_pkg::reg_addr_t    rs1_addr;
   regfile_pkg::reg_addr_t    rs2_addr;
   regfile_pkg::xdata_t       rf_qa;
   regfile_pkg::xdata_t       rf_qb;
   regfile_pkg::xdata_t       rs1_data;
   regfile_pkg::xdata_t       rs2_data;

   logic                      init_done;

   modport slave (
      input  ex_valid, ex_rd, ex_data, ld_valid, ld_rd, ld_data,
      input  rs1_addr, rs2_addr, rf_qa, rf_qb,
      output ex_ready, ld_ready, rf_we, rf_rd, rf_di, rs1_data, rs2_data, init_done
   );

   modport master (
      output ex_valid, ex_rd, ex_data, ld_valid, ld_rd, ld_data,
      output rs1_addr, rs2_addr, rf_qa, rf_qb,
      input  ex_ready, ld_ready, rf_we, rf_rd, rf_di, rs1_data, rs2_data, init_done
   );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter for the register-file write port.
// Ports: clk, rst_n (sync, active-low), run_en (grants allowed), req[1:0]
// indexed by SRC_EX/SRC_LD, gnt[1:0] one-hot combinational grant.
// pri names the source that wins a tie; it moves to the loser after each grant.
module wb_rr_arbiter
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run_en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic pri_q;

   always_comb begin
      gnt = '0;
      if (run_en) begin
         if (req[SRC_EX] && req[SRC_LD]) begin
            gnt[pri_q] = 1'b1;
         end else begin
            gnt = req;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pri_q <= SRC_LD;
      end else if (gnt[SRC_EX]) begin
         pri_q <= SRC_LD;
      end else if (gnt[SRC_LD]) begin
         pri_q <= SRC_EX;
      end
   end

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file write-back controller.
// Ports: clk, rst_n (sync, active-low), bus (regfile_ctrl_if.slave).
// After reset it writes zero to every register (the SRAM has no reset), then
// arbitrates the single write port between ex and ld, presenting each accepted
// write one cycle later on the registered rf_we/rf_rd/rf_di. Read ports are
// bypassed against the write in flight and x0 is forced to zero.
module regfile_ctrl
   import regfile_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   regfile_ctrl_if.slave  bus
);

   state_e    state_q;
   reg_addr_t cnt_q;
   logic      rf_we_q;
   reg_addr_t rf_rd_q;
   xdata_t    rf_di_q;
   logic      init_done_q;

   logic [1:0] gnt;
   reg_addr_t  win_rd;
   xdata_t     win_data;

   wb_rr_arbiter u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .run_en (state_q == ST_RUN),
      .req    ({bus.ld_valid, bus.ex_valid}),
      .gnt    (gnt)
   );

   assign bus.ex_ready = gnt[SRC_EX];
   assign bus.ld_ready = gnt[SRC_LD];

   assign win_rd   = gnt[SRC_LD] ? bus.ld_rd   : bus.ex_rd;
   assign win_data = gnt[SRC_LD] ? bus.ld_data : bus.ex_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         rf_we_q     <= 1'b0;
         rf_rd_q     <= '0;
         rf_di_q     <= '0;
         init_done_q <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               rf_we_q <= 1'b1;
               rf_rd_q <= cnt_q;
               rf_di_q <= '0;
               // Counter parks at the last register; it never wraps.
               if (cnt_q == REG_AW'(NREG - 1)) begin
                  state_q     <= ST_RUN;
                  init_done_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + reg_addr_t'(1);
               end
            end
            ST_RUN: begin
               if (|gnt) begin
                  // x0 writes are accepted but suppressed at the SRAM.
                  rf_we_q <= (win_rd != '0);
                  rf_rd_q <= win_rd;
                  rf_di_q <= win_data;
               end else begin
                  rf_we_q <= 1'b0;
               end
            end
            default: state_q <= ST_INIT;
         endcase
      end
   end

   assign bus.rf_we     = rf_we_q;
   assign bus.rf_rd     = rf_rd_q;
   assign bus.rf_di     = rf_di_q;
   assign bus.init_done = init_done_q;

   assign bus.rs1_data = bypass(bus.rs1_addr, rf_we_q, rf_rd_q, rf_di_q, bus.rf_qa);
   assign bus.rs2_data = bypass(bus.rs2_addr, rf_we_q, rf_rd_q, rf_di_q, bus.rf_qb);

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl: a behavioural model of the architectural
// register contents, arbitration fairness and the init sweep is advanced once per
// clock and compared with the DUT; directed sequences cover the corner cases.
module tb_regfile_ctrl;
   import regfile_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   regfile_ctrl_if bus ();

   regfile_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #10 clk = ~clk;

   // SRAM stand-in, raw reads with an optional override for directed bypass vectors.
   xdata_t sram [NREG];
   logic   ovr_en;
   xdata_t ovr_qa, ovr_qb;

   always @(posedge clk) begin
      if (bus.rf_we) sram[bus.rf_rd] = bus.rf_di;
   end

   assign bus.rf_qa = ovr_en ? ovr_qa : sram[bus.rs1_addr];
   assign bus.rf_qb = ovr_en ? ovr_qb : sram[bus.rs2_addr];

   typedef struct {
      reg_addr_t a1;
      reg_addr_t a2;
      xdata_t    qa;
      xdata_t    qb;
      xdata_t    e1;
      xdata_t    e2;
   } byp_vec_t;

   byp_vec_t byp_tab [5];

   int n_cmp = 0;
   int n_bad = 0;

   // Model state.
   bit        m_known = 1'b0;
   int        m_init  = 0;      // registers zeroed so far; 32 = running
   bit        m_pri   = 1'b1;   // tie winner: 0 = ex, 1 = ld
   bit        m_we    = 1'b0;
   reg_addr_t m_rd    = '0;
   xdata_t    m_di    = '0;
   xdata_t    arch [NREG];
   bit        arch_ok [NREG];
   bit        acc_ex, acc_ld;
   bit        dut_ex_rdy, dut_ld_rdy;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_read(input string name, input reg_addr_t a, input xdata_t act);
      if (a == '0) chk(name, act, 32'h0);
      else if (arch_ok[a]) chk(name, act, arch[a]);
   endtask

   // One clock: check combinational outputs, advance the model at the edge,
   // then check registered outputs on the falling edge.
   task automatic cycle();
      bit        run, gex, gld;
      reg_addr_t ex_rd, ld_rd;
      xdata_t    ex_d, ld_d;
      #1;
      run = m_known && (m_init == 32);
      gex = 1'b0;
      gld = 1'b0;
      if (run) begin
         if (bus.ex_valid && bus.ld_valid) begin
            gex = !m_pri;
            gld = m_pri;
         end else begin
            gex = bus.ex_valid;
            gld = bus.ld_valid;
         end
      end
      dut_ex_rdy = bus.ex_ready;
      dut_ld_rdy = bus.ld_ready;
      if (m_known) begin
         chk("ex_ready", 32'(bus.ex_ready), 32'(gex));
         chk("ld_ready", 32'(bus.ld_ready), 32'(gld));
         chk_read("rs1_data", bus.rs1_addr, bus.rs1_data);
         chk_read("rs2_data", bus.rs2_addr, bus.rs2_data);
      end
      ex_rd = bus.ex_rd;
      ld_rd = bus.ld_rd;
      ex_d  = bus.ex_data;
      ld_d  = bus.ld_data;
      acc_ex = gex && rst_n;
      acc_ld = gld && rst_n;
      @(posedge clk);
      if (!rst_n) begin
         m_known = 1'b1;
         m_init  = 0;
         m_pri   = 1'b1;
         m_we    = 1'b0;
         m_rd    = '0;
         m_di    = '0;
         for (int i = 0; i < int'(NREG); i++) arch_ok[i] = 1'b0;
      end else if (m_known && m_init < 32) begin
         m_we = 1'b1;
         m_rd = 5'(m_init);
         m_di = '0;
         arch[m_init]    = '0;
         arch_ok[m_init] = 1'b1;
         m_init++;
      end else if (acc_ex || acc_ld) begin
         m_rd  = acc_ld ? ld_rd : ex_rd;
         m_di  = acc_ld ? ld_d  : ex_d;
         m_we  = (m_rd != '0);
         m_pri = acc_ex;
         if (m_rd != '0) begin
            arch[m_rd]    = m_di;
            arch_ok[m_rd] = 1'b1;
         end
      end else begin
         m_we = 1'b0;
      end
      @(negedge clk);
      if (m_known) begin
         chk("rf_we", 32'(bus.rf_we), 32'(m_we));
         chk("rf_rd", 32'(bus.rf_rd), 32'(m_rd));
         chk("rf_di", bus.rf_di, m_di);
         chk("init_done", 32'(bus.init_done), 32'(m_init == 32));
      end
   endtask

   int n_gex, n_gld, n_we;

   initial begin
      byp_tab[0] = '{5'd7,  5'd7, 32'h0,        32'h0,        32'h12345678, 32'h12345678};
      byp_tab[1] = '{5'd7,  5'd8, 32'h0,        32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D};
      byp_tab[2] = '{5'd0,  5'd7, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h12345678};
      byp_tab[3] = '{5'd8,  5'd0, 32'h11111111, 32'hFFFFFFFF, 32'h11111111, 32'h0};
      byp_tab[4] = '{5'd31, 5'd6, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5A};

      ovr_en = 1'b0;
      ovr_qa = '0;
      ovr_qb = '0;
      bus.rs1_addr = '0;
      bus.rs2_addr = '0;
      bus.ex_valid = 1'b1;
      bus.ex_rd    = 5'd5;
      bus.ex_data  = 32'hAAAA0001;
      bus.ld_valid = 1'b1;
      bus.ld_rd    = 5'd6;
      bus.ld_data  = 32'h55550002;

      // Reset, then the 32-cycle zeroing sweep with both sources already waiting.
      @(negedge clk);
      rst_n = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) cycle();
      chk("init_done_after_e32", 32'(bus.init_done), 32'h1);

      // Tie: ld first, then ex.
      cycle();
      if (acc_ld) bus.ld_valid = 1'b0;
      chk("tie_first_rd", 32'(bus.rf_rd), 32'd6);
      cycle();
      if (acc_ex) bus.ex_valid = 1'b0;
      chk("tie_second_rd", 32'(bus.rf_rd), 32'd5);
      chk("tie_second_di", bus.rf_di, 32'hAAAA0001);

      // x0 write is accepted but not written.
      bus.ex_valid = 1'b1;
      bus.ex_rd    = 5'd0;
      bus.ex_data  = 32'hDEADBEEF;
      cycle();
      if (acc_ex) bus.ex_valid = 1'b0;
      chk("x0_accepted", 32'(dut_ex_rdy), 32'h1);
      chk("x0_no_we", 32'(bus.rf_we), 32'h0);
      ovr_en = 1'b1;
      ovr_qa = 32'hFFFFFFFF;
      #1;
      chk("x0_read", bus.rs1_data, 32'h0);
      ovr_en = 1'b0;

      // Bypass vectors against an in-flight write to x7.
      bus.ex_valid = 1'b1;
      bus.ex_rd    = 5'd7;
      bus.ex_data  = 32'h12345678;
      cycle();
      if (acc_ex) bus.ex_valid = 1'b0;
      ovr_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.rs1_addr = byp_tab[i].a1;
         bus.rs2_addr = byp_tab[i].a2;
         ovr_qa = byp_tab[i].qa;
         ovr_qb = byp_tab[i].qb;
         #1;
         chk($sformatf("byp%0d_rs1", i), bus.rs1_data, byp_tab[i].e1);
         chk($sformatf("byp%0d_rs2", i), bus.rs2_data, byp_tab[i].e2);
      end
      ovr_en = 1'b0;
      bus.rs1_addr = '0;
      bus.rs2_addr = '0;

      // Saturation: both always valid for 10 cycles; ld wins first.
      n_gex = 0;
      n_gld = 0;
      n_we  = 0;
      bus.ex_valid = 1'b1;
      bus.ex_rd    = 5'd1;
      bus.ex_data  = 32'h0E000000;
      bus.ld_valid = 1'b1;
      bus.ld_rd    = 5'd16;
      bus.ld_data  = 32'h01000000;
      for (int k = 0; k < 10; k++) begin
         cycle();
         chk("sat_alt_ld", 32'(dut_ld_rdy), 32'(k % 2 == 0));
         n_gex += int'(dut_ex_rdy);
         n_gld += int'(dut_ld_rdy);
         n_we  += int'(bus.rf_we);
         if (acc_ex) begin
            bus.ex_rd   = 5'(k + 2);
            bus.ex_data = 32'h0E000000 + 32'(k);
         end
         if (acc_ld) begin
            bus.ld_rd   = 5'(k + 17);
            bus.ld_data = 32'h01000000 + 32'(k);
         end
      end
      chk("sat_ex_grants", 32'(n_gex), 32'd5);
      chk("sat_ld_grants", 32'(n_gld), 32'd5);
      chk("sat_we_cycles", 32'(n_we), 32'd10);
      bus.ex_valid = 1'b0;
      bus.ld_valid = 1'b0;
      cycle();

      // Reset mid-run with ld held; handshake dropped, re-accepted after new init.
      bus.ld_valid = 1'b1;
      bus.ld_rd    = 5'd9;
      bus.ld_data  = 32'h0BADF00D;
      rst_n = 1'b0;
      cycle();
      chk("rst_mid_we", 32'(bus.rf_we), 32'h0);
      chk("rst_mid_init_done", 32'(bus.init_done), 32'h0);
      rst_n = 1'b1;
      cycle();
      chk("reinit_rd0", 32'(bus.rf_rd), 32'd0);
      for (int i = 1; i < 32; i++) cycle();
      cycle();
      if (acc_ld) bus.ld_valid = 1'b0;
      chk("reaccept_rd", 32'(bus.rf_rd), 32'd9);
      chk("reaccept_di", bus.rf_di, 32'h0BADF00D);

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         rst_n = ($urandom_range(0, 249) != 0);
         if (!bus.ex_valid || acc_ex) begin
            bus.ex_valid = ($urandom_range(0, 9) < 6);
            bus.ex_rd    = 5'($urandom_range(0, 31));
            bus.ex_data  = $urandom;
         end
         if (!bus.ld_valid || acc_ld) begin
            bus.ld_valid = ($urandom_range(0, 9) < 6);
            bus.ld_rd    = 5'($urandom_range(0, 31));
            bus.ld_data  = $urandom;
         end
         bus.rs1_addr = 5'($urandom_range(0, 31));
         bus.rs2_addr = 5'($urandom_range(0, 31));
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
